// File: rtl/sys_pio_pkg.sv
// Shared constants for the system PIO blocks: register window, edge and interrupt selections.
package sys_pio_pkg;

    localparam int PIO_BUS_W = 32;

    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_RSVD    = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/sys_pio_sync.sv
// Two-stage synchronizer for a WIDTH-bit bus, synchronous active-low reset.
module sys_pio_sync #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so dout takes meta_q's pre-edge value (a true 2-stage shift).
        if (!reset_n) begin
            meta_q <= '0;
            dout   <= '0;
        end else begin
            meta_q <= din;
            dout   <= meta_q;
        end
    end

endmodule

// File: rtl/sys_pio_in.sv
// sys_pio_in: Avalon-MM input PIO with sticky edge capture and maskable interrupt.
// Build option: define SYS_PIO_IN_SYNC_EN to put a two-flop synchronizer ahead of data_q.
module sys_pio_in
    import sys_pio_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int EDGE_TYPE = EDGE_RISE,
    parameter int IRQ_TYPE  = IRQ_EDGE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [PIO_BUS_W-1:0] writedata,
    input  logic [WIDTH-1:0]     in_port,
    output logic [PIO_BUS_W-1:0] readdata,
    output logic                 irq
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic             unused_bits;

`ifdef SYS_PIO_IN_SYNC_EN
    localparam logic [1:0] DEPTH = 2'd3;

    // data_q is the synchronizer's second stage.
    sys_pio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (data_q)
    );
`else
    localparam logic [1:0] DEPTH = 2'd2;

    always_ff @(posedge clk) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= in_port;
    end
`endif

    assign wr_en       = chipselect && !write_n;
    assign armed       = (arm_cnt == DEPTH);
    assign clr         = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign unused_bits = ^writedata;

    always_comb begin
        // NOTE: default assigned first so every path drives edge_hit and no latch is inferred.
        edge_hit = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = data_q & ~prev_q;
            EDGE_FALL: edge_hit = ~data_q & prev_q;
            default:   edge_hit = (data_q & ~prev_q) | (~data_q & prev_q);
        endcase
    end

    // Until the pipeline has filled from its reset zeros, a pin already high looks like a rise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            arm_cnt <= '0;
        end else begin
            prev_q <= data_q;
            if (wr_en && address == PIO_ADDR_IRQMASK) mask_q <= writedata[WIDTH-1:0];
            cap_q <= (cap_q & ~clr) | (edge_hit & {WIDTH{armed}});
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = data_q;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
            default:          readdata = '0;
        endcase
    end

    generate
        if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
            assign irq = |(data_q & mask_q);
        end else begin : g_irq_edge
            assign irq = |(cap_q & mask_q);
        end
    endgenerate

endmodule

// File: tb/tb_sys_pio_in.sv
// Bench for sys_pio_in: three instances (rise/edge-irq, any/edge-irq, rise/level-irq) on one bus,
// checked against a pin-history reference model. Honors SYS_PIO_IN_SYNC_EN like the RTL.
module tb_sys_pio_in;
    import sys_pio_pkg::*;

    localparam int W = 10;
`ifdef SYS_PIO_IN_SYNC_EN
    localparam int LAT   = 2;
    localparam int DEPTH = 3;
`else
    localparam int LAT   = 1;
    localparam int DEPTH = 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_rise, rd_any, rd_lvl;
    logic          irq_rise, irq_any, irq_lvl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sys_pio_in #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .IRQ_TYPE(IRQ_EDGE)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise));

    sys_pio_in #(.WIDTH(W), .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_EDGE)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any));

    sys_pio_in #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .IRQ_TYPE(IRQ_LEVEL)) u_lvl (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_lvl), .irq(irq_lvl));

    // Reference model: pins[0] is the newest sample taken at a clock edge.
    logic [W-1:0] pins [3];
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap [3];
    int           since;

    function automatic logic [W-1:0] m_data();
        return pins[LAT-1];
    endfunction

    function automatic logic [W-1:0] m_prev();
        return pins[LAT];
    endfunction

    // Per-bit edge detection from the level seen now versus one sample earlier.
    function automatic logic [W-1:0] m_edges(input int kind);
        logic [W-1:0] d, p, r;
        d = m_data();
        p = m_prev();
        r = '0;
        for (int b = 0; b < W; b++) begin
            if (d[b] != p[b]) begin
                if (kind == EDGE_ANY) r[b] = 1'b1;
                else if (kind == EDGE_RISE) r[b] = d[b];
                else r[b] = !d[b];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int inst, input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        if (a == 2'd0) v[W-1:0] = m_data();
        else if (a == 2'd2) v[W-1:0] = m_mask;
        else if (a == 2'd3) v[W-1:0] = m_cap[inst];
        return v;
    endfunction

    function automatic logic m_irq(input int inst);
        if (inst == 2) return (m_data() & m_mask) != '0;
        return (m_cap[inst] & m_mask) != '0;
    endfunction

    // Advance the model across one clock edge using the inputs present before it.
    task automatic model_edge();
        logic [W-1:0] e [3];
        logic [W-1:0] clr;
        logic         armed, wr;
        armed = (since >= DEPTH);
        e[0]  = m_edges(EDGE_RISE);
        e[1]  = m_edges(EDGE_ANY);
        e[2]  = m_edges(EDGE_RISE);
        wr    = chipselect && !write_n;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                pins[i]  = '0;
                m_cap[i] = '0;
            end
            m_mask = '0;
            since  = 0;
        end else begin
            clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int i = 0; i < 3; i++)
                m_cap[i] = (m_cap[i] & ~clr) | (armed ? e[i] : '0);
            if (wr && address == 2'd2) m_mask = writedata[W-1:0];
            pins[2] = pins[1];
            pins[1] = pins[0];
            pins[0] = in_port;
            if (since < 3) since++;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/rd_rise"},  rd_rise,         m_read(0, address));
        check({tag, "/rd_any"},   rd_any,          m_read(1, address));
        check({tag, "/rd_lvl"},   rd_lvl,          m_read(2, address));
        check({tag, "/irq_rise"}, {31'd0, irq_rise}, {31'd0, m_irq(0)});
        check({tag, "/irq_any"},  {31'd0, irq_any},  {31'd0, m_irq(1)});
        check({tag, "/irq_lvl"},  {31'd0, irq_lvl},  {31'd0, m_irq(2)});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic look(input logic [1:0] a);
        address = a;
        #1;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } bus_vec_t;

    bus_vec_t vecs [8];

    initial begin
        // Bus-decode vectors, applied with in_port held at 0x3FF and no captures pending.
        vecs[0] = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd2, 32'h0000_03FF};
        vecs[1] = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
        vecs[2] = '{2'd2, 1'b0, 1'b0, 32'h0000_0000, 2'd2, 32'h0000_03FF};
        vecs[3] = '{2'd0, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 32'h0000_03FF};
        vecs[4] = '{2'd0, 1'b1, 1'b0, 32'h0000_0123, 2'd0, 32'h0000_03FF};
        vecs[5] = '{2'd2, 1'b1, 1'b1, 32'h0000_0000, 2'd2, 32'h0000_03FF};
        vecs[6] = '{2'd2, 1'b1, 1'b0, 32'hFFFF_F0A5, 2'd2, 32'h0000_00A5};
        vecs[7] = '{2'd2, 1'b1, 1'b0, 32'h0000_0000, 2'd2, 32'h0000_0000};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 10'h3FF;
        repeat (3) cycle();

        for (int a = 0; a < 4; a++) begin
            look(a[1:0]);
            check($sformatf("reset_rd_rise_a%0d", a), rd_rise, 32'h0);
            check($sformatf("reset_rd_any_a%0d", a),  rd_any,  32'h0);
        end
        check("reset_irq_rise", {31'd0, irq_rise}, 32'h0);
        check("reset_irq_lvl",  {31'd0, irq_lvl},  32'h0);

        // Release with the pin already high: no capture may appear.
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            look(2'd3);
            check($sformatf("arm_cap_rise_c%0d", c), rd_rise, 32'h0);
            check($sformatf("arm_cap_any_c%0d", c),  rd_any,  32'h0);
            check_all("arm");
        end
        look(2'd0);
        check("arm_data", rd_rise, 32'h3FF);

        for (int i = 0; i < 8; i++) begin
            address    = vecs[i].addr;
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wn;
            writedata  = vecs[i].wd;
            cycle();
            chipselect = 1'b0;
            write_n    = 1'b1;
            writedata  = '0;
            look(vecs[i].raddr);
            check($sformatf("bus_vec%0d", i), rd_rise, vecs[i].exp);
            check_all($sformatf("bus_vec%0d", i));
        end

        // Rising edges on bits 0 and 2 with only bit 0 unmasked.
        in_port = '0;
        repeat (4) cycle();
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h1);
        in_port = 10'h005;
        repeat (LAT) cycle();
        look(2'd3);
        check("rise_not_yet", rd_rise, 32'h0);
        cycle();
        look(2'd3);
        check("rise_cap", rd_rise, 32'h005);
        check("rise_irq", {31'd0, irq_rise}, 32'h1);
        check_all("rise");
        bus_write(2'd3, 32'h1);
        look(2'd3);
        check("rise_clr_cap", rd_rise, 32'h004);
        check("rise_clr_irq", {31'd0, irq_rise}, 32'h0);
        check_all("rise_clr");

        // Capture and clear of bit 0 land on the same edge: capture wins.
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = '0;
        repeat (3) cycle();
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = 10'h001;
        repeat (LAT) cycle();
        bus_write(2'd3, 32'h1);
        look(2'd3);
        check("set_wins_cap", rd_rise, 32'h001);
        check_all("set_wins");

        // Any-edge: fall then rise on bit 9.
        in_port = 10'h200;
        repeat (4) cycle();
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = '0;
        repeat (LAT + 1) cycle();
        look(2'd3);
        check("any_fall_cap", rd_any, 32'h200);
        check("any_fall_rise_inst", rd_rise, 32'h0);
        in_port = 10'h200;
        repeat (LAT + 2) cycle();
        look(2'd3);
        check("any_rise_cap", rd_any, 32'h200);
        check("any_rise_rise_inst", rd_rise, 32'h200);
        bus_write(2'd3, 32'hFFFF_FFFF);
        look(2'd3);
        check("any_clr_cap", rd_any, 32'h0);
        check_all("any");

        // Level interrupt follows data_q with no software clear.
        in_port = '0;
        repeat (4) cycle();
        bus_write(2'd2, 32'h010);
        in_port = 10'h010;
        look(2'd0);
        check("lvl_before", {31'd0, irq_lvl}, 32'h0);
        repeat (LAT) cycle();
        check("lvl_high", {31'd0, irq_lvl}, 32'h1);
        in_port = '0;
        repeat (LAT) cycle();
        check("lvl_low", {31'd0, irq_lvl}, 32'h0);
        check_all("lvl");

        // Reset in the middle of activity wipes captures and mask.
        bus_write(2'd2, 32'h3FF);
        in_port = 10'h3FF;
        repeat (4) cycle();
        look(2'd3);
        check("midrst_pre_cap", rd_rise, 32'h3FF);
        reset_n = 1'b0;
        cycle();
        look(2'd3);
        check("midrst_cap", rd_rise, 32'h0);
        check("midrst_irq", {31'd0, irq_rise}, 32'h0);
        check_all("midrst");
        reset_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            in_port    = W'($urandom);
            address    = 2'($urandom);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom);
            writedata  = $urandom;
            reset_n    = ($urandom_range(0, 63) != 0);
            #1;
            check_all("rand");
            cycle();
        end
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
